ram_arbiter: RTL and testbench
==============================

RAM_ARBITER -- requirements
Module: ram_arbiter

Interface
REQ-001 Parameter: AW, 16, address width.
REQ-002 Parameter: DW, 8, data width.
REQ-003 Parameter: LOCK_MAX, 64, maximum cycles the loader may hold a lock.
REQ-004 Port: clk  in  1  single clock; all state changes on posedge clk.
REQ-005 Port: rst_n  in  1  asynchronous, active-low reset.
REQ-006 Ports: cpu_req, cpu_we  in  1 each  CPU memory request (from the control word MEM_EN/RAM_WRITE) and its write qualifier.
REQ-007 Ports: cpu_addr  in  AW, cpu_wdata  in  DW  CPU request address and write data.
REQ-008 Ports: ldr_req, ldr_we, ldr_lock  in  1 each  loader/DMA request, write qualifier, and bus-lock request.
REQ-009 Ports: ldr_addr  in  AW, ldr_wdata  in  DW  loader request address and write data.
REQ-010 Ports: cpu_gnt, ldr_gnt  out  1 each  access accepted this cycle.
REQ-011 Ports: cpu_rvalid, ldr_rvalid  out  1 each  read data valid; cpu_rdata, ldr_rdata  out  DW.
REQ-012 Port: cpu_stall  out  1  equals cpu_req & ~cpu_gnt; freezes the control-unit stage counter.
REQ-013 Ports: ram_en, ram_we  out  1; ram_addr  out  AW; ram_wdata  out  DW; ram_rdata  in  DW  single-port RAM with 1-cycle read latency.
REQ-014 Port: lock_err  out  1  sticky flag set on a forced lock release.

Function
REQ-015 At most one grant per cycle; gnt is combinational from the current requests and registered state.
REQ-016 On grant, ram_en=1 and ram_we/ram_addr/ram_wdata mirror the winner in the same cycle; with no grant, ram_en=0 and ram_we=0.
REQ-017 For a granted read, the winner's rvalid=1 and rdata=ram_rdata in cycle t+1; rdata is routed by a registered owner bit; writes produce no rvalid.
REQ-018 A requester holds req/we/addr/wdata stable until gnt; one gnt consumes one access.
REQ-019 States: OPEN, LOCKED, BLOCKED.
REQ-020 OPEN/BLOCKED, single requester: that requester is granted.
REQ-021 OPEN/BLOCKED, both requesting: round-robin on prio; prio flips to the other port after every grant.
REQ-022 OPEN -> LOCKED when ldr_gnt & ldr_lock; lock counter loads 1.
REQ-023 LOCKED: only the loader is granted; the CPU stalls; the counter increments each cycle while the lock is held.
REQ-024 LOCKED -> OPEN when ldr_lock=0 is sampled before the counter reaches LOCK_MAX.
REQ-025 LOCKED -> BLOCKED when the counter equals LOCK_MAX with ldr_lock=1; this sets lock_err and prio=CPU.
REQ-026 BLOCKED: arbitration as OPEN, but ldr_lock is ignored; BLOCKED -> OPEN when ldr_lock=0 is sampled.
REQ-027 A request deasserted before its grant is dropped silently; read rvalid still follows any already granted read.

Reset
REQ-028 On rst_n low: state=OPEN, prio=CPU, counter=0, owner=CPU, lock_err=0; all gnt, rvalid, ram_en and ram_we are 0; rdata is 0.
REQ-029 Reset asserted mid-read suppresses the pending rvalid.
REQ-030 Release of rst_n takes effect at the first posedge clk after it goes high.

Structure
REQ-031 Package sap3_pkg holds AW/DW defaults, the arb_state_t enum (OPEN/LOCKED/BLOCKED) and port indices PORT_CPU=0/PORT_LDR=1.
REQ-032 One sub-module, rr_arb2, implements the 2-way round-robin grant and prio update; the lock FSM, counter and read routing stay in ram_arbiter.

Verification
REQ-033 CPU-only read: cpu_req=1, we=0, addr=0x0010, RAM[0x0010]=0xA5 -> cpu_gnt and ram_en at t, cpu_rvalid with cpu_rdata=0xA5 at t+1, cpu_stall=0.
REQ-034 Both request from reset, 4 cycles -> grants CPU, LDR, CPU, LDR; cpu_stall=1 exactly on the LDR cycles.
REQ-035 Loader writes with ldr_lock=1 for 10 cycles, then drops it, while the CPU requests throughout -> 10 ldr_gnt with no cpu_gnt, then cpu_gnt in the first OPEN cycle; lock_err=0.
REQ-036 With LOCK_MAX=4, ldr_lock held for 20 cycles -> forced release after 4 loader grants, lock_err=1, next grant to CPU, then round-robin until ldr_lock falls.
REQ-037 rst_n pulsed low in the cycle after a granted read -> no rvalid, all outputs 0, state OPEN, lock_err cleared.

Source files
------------

// File: rtl/sap3_pkg.sv
// Shared defaults, arbiter state encoding and port indices for the RAM arbiter.
package sap3_pkg;

  localparam int unsigned AW_DEF       = 16;
  localparam int unsigned DW_DEF       = 8;
  localparam int unsigned LOCK_MAX_DEF = 64;

  typedef enum logic [1:0] {
    OPEN    = 2'd0,
    LOCKED  = 2'd1,
    BLOCKED = 2'd2
  } arb_state_t;

  localparam logic PORT_CPU = 1'b0;
  localparam logic PORT_LDR = 1'b1;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter.
//   req_cpu_c/req_ldr_c : qualified requests
//   prio                : port that wins a tie
//   gnt_cpu_c/gnt_ldr_c : one-hot-or-zero grant
//   prio_nxt_c          : priority after this cycle (the other port once one wins)
module rr_arb2
  import sap3_pkg::*;
(
  input  logic req_cpu_c,
  input  logic req_ldr_c,
  input  logic prio,
  output logic gnt_cpu_c,
  output logic gnt_ldr_c,
  output logic prio_nxt_c
);

  always_comb begin
    gnt_cpu_c  = req_cpu_c & (~req_ldr_c | (prio == PORT_CPU));
    gnt_ldr_c  = req_ldr_c & ~gnt_cpu_c;
    prio_nxt_c = prio;
    if (gnt_cpu_c)      prio_nxt_c = PORT_LDR;
    else if (gnt_ldr_c) prio_nxt_c = PORT_CPU;
  end

endmodule

// File: rtl/ram_arbiter.sv
// Arbitrates a single-port RAM between the CPU and a loader/DMA port with
// an optional, time-limited loader bus lock.
//   cpu_*      : CPU request/write qualifier/address/data, grant, stall, read return
//   ldr_*      : loader request/write/lock/address/data, grant, read return
//   ram_*      : RAM port, 1-cycle read latency
//   lock_err   : sticky, set when a lock is forcibly released at LOCK_MAX
module ram_arbiter
  import sap3_pkg::*;
#(
  parameter int unsigned AW       = AW_DEF,
  parameter int unsigned DW       = DW_DEF,
  parameter int unsigned LOCK_MAX = LOCK_MAX_DEF
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  input  logic          ldr_req,
  input  logic          ldr_we,
  input  logic          ldr_lock,
  input  logic [AW-1:0] ldr_addr,
  input  logic [DW-1:0] ldr_wdata,
  output logic          cpu_gnt,
  output logic          ldr_gnt,
  output logic          cpu_rvalid,
  output logic          ldr_rvalid,
  output logic [DW-1:0] cpu_rdata,
  output logic [DW-1:0] ldr_rdata,
  output logic          cpu_stall,
  output logic          ram_en,
  output logic          ram_we,
  output logic [AW-1:0] ram_addr,
  output logic [DW-1:0] ram_wdata,
  input  logic [DW-1:0] ram_rdata,
  output logic          lock_err
);

  localparam int unsigned CW = $clog2(LOCK_MAX + 1);

  arb_state_t    state;
  logic          prio;
  logic          owner;
  logic [CW-1:0] lock_cnt;
  logic          lock_full_c;
  logic          req_cpu_c;
  logic          req_ldr_c;
  logic          prio_nxt_c;

  // Lock has run its full budget and is still asserted: this cycle grants nobody.
  assign lock_full_c = (state == LOCKED) && ldr_lock && (lock_cnt == CW'(LOCK_MAX));
  assign req_cpu_c   = cpu_req & (state != LOCKED);
  assign req_ldr_c   = ldr_req & ~lock_full_c;

  rr_arb2 u_rr (
    .req_cpu_c (req_cpu_c),
    .req_ldr_c (req_ldr_c),
    .prio      (prio),
    .gnt_cpu_c (cpu_gnt),
    .gnt_ldr_c (ldr_gnt),
    .prio_nxt_c(prio_nxt_c)
  );

  assign cpu_stall = cpu_req & ~cpu_gnt;

  // RAM port mirrors the winner; idle cycles keep ram_we low.
  always_comb begin
    ram_en    = cpu_gnt | ldr_gnt;
    ram_we    = 1'b0;
    ram_addr  = cpu_addr;
    ram_wdata = cpu_wdata;
    if (ldr_gnt) begin
      ram_we    = ldr_we;
      ram_addr  = ldr_addr;
      ram_wdata = ldr_wdata;
    end else if (cpu_gnt) begin
      ram_we    = cpu_we;
    end
  end

  // Read data arrives one cycle after the grant; steer it by the registered owner.
  assign cpu_rdata = (cpu_rvalid && (owner == PORT_CPU)) ? ram_rdata : '0;
  assign ldr_rdata = (ldr_rvalid && (owner == PORT_LDR)) ? ram_rdata : '0;

  // Read tracking and round-robin priority.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cpu_rvalid <= 1'b0;
      ldr_rvalid <= 1'b0;
      owner      <= PORT_CPU;
      prio       <= PORT_CPU;
    end else begin
      cpu_rvalid <= cpu_gnt & ~cpu_we;
      ldr_rvalid <= ldr_gnt & ~ldr_we;
      if (ldr_gnt)      owner <= PORT_LDR;
      else if (cpu_gnt) owner <= PORT_CPU;
      prio <= lock_full_c ? PORT_CPU : prio_nxt_c;
    end
  end

  // Lock FSM with hold counter and sticky forced-release flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= OPEN;
      lock_cnt <= '0;
      lock_err <= 1'b0;
    end else begin
      case (state)
        OPEN: begin
          if (ldr_gnt && ldr_lock) begin
            state    <= LOCKED;
            lock_cnt <= CW'(1);
          end
        end
        LOCKED: begin
          if (!ldr_lock) begin
            state    <= OPEN;
            lock_cnt <= '0;
          end else if (lock_full_c) begin
            state    <= BLOCKED;
            lock_cnt <= '0;
            lock_err <= 1'b1;
          end else begin
            lock_cnt <= lock_cnt + CW'(1);
          end
        end
        BLOCKED: begin
          if (!ldr_lock) state <= OPEN;
        end
        default: begin
          state    <= OPEN;
          lock_cnt <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench for ram_arbiter: a default instance (LOCK_MAX=64) backed by a
// RAM model, and a LOCK_MAX=4 instance sharing its inputs for forced release.
module tb_ram_arbiter;

  logic        clk;
  logic        rst_n;
  logic        cpu_req, cpu_we, ldr_req, ldr_we, ldr_lock;
  logic [15:0] cpu_addr, ldr_addr;
  logic [7:0]  cpu_wdata, ldr_wdata;

  logic        cpu_gnt, ldr_gnt, cpu_rvalid, ldr_rvalid, cpu_stall;
  logic [7:0]  cpu_rdata, ldr_rdata;
  logic        ram_en, ram_we, lock_err;
  logic [15:0] ram_addr;
  logic [7:0]  ram_wdata, ram_rdata;

  logic        cpu_gnt4, ldr_gnt4, cpu_rvalid4, ldr_rvalid4, cpu_stall4;
  logic [7:0]  cpu_rdata4, ldr_rdata4;
  logic        ram_en4, ram_we4, lock_err4;
  logic [15:0] ram_addr4;
  logic [7:0]  ram_wdata4;
  logic [7:0]  ram_rdata4;

  logic [7:0]  mem [0:255];

  int n_chk = 0;
  int n_err = 0;

  assign ram_rdata4 = 8'h00;

  ram_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .ldr_req(ldr_req), .ldr_we(ldr_we), .ldr_lock(ldr_lock),
    .ldr_addr(ldr_addr), .ldr_wdata(ldr_wdata),
    .cpu_gnt(cpu_gnt), .ldr_gnt(ldr_gnt),
    .cpu_rvalid(cpu_rvalid), .ldr_rvalid(ldr_rvalid),
    .cpu_rdata(cpu_rdata), .ldr_rdata(ldr_rdata),
    .cpu_stall(cpu_stall),
    .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr),
    .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
    .lock_err(lock_err)
  );

  ram_arbiter #(.LOCK_MAX(4)) dut4 (
    .clk(clk), .rst_n(rst_n),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .ldr_req(ldr_req), .ldr_we(ldr_we), .ldr_lock(ldr_lock),
    .ldr_addr(ldr_addr), .ldr_wdata(ldr_wdata),
    .cpu_gnt(cpu_gnt4), .ldr_gnt(ldr_gnt4),
    .cpu_rvalid(cpu_rvalid4), .ldr_rvalid(ldr_rvalid4),
    .cpu_rdata(cpu_rdata4), .ldr_rdata(ldr_rdata4),
    .cpu_stall(cpu_stall4),
    .ram_en(ram_en4), .ram_we(ram_we4), .ram_addr(ram_addr4),
    .ram_wdata(ram_wdata4), .ram_rdata(ram_rdata4),
    .lock_err(lock_err4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single-port RAM model, 1-cycle read latency.
  always @(posedge clk) begin
    if (ram_en) begin
      if (ram_we) mem[ram_addr[7:0]] <= ram_wdata;
      else        ram_rdata <= mem[ram_addr[7:0]];
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    cpu_req = 0; cpu_we = 0; cpu_addr = '0; cpu_wdata = '0;
    ldr_req = 0; ldr_we = 0; ldr_lock = 0; ldr_addr = '0; ldr_wdata = '0;
  endtask

  task automatic do_reset();
    next_cycle();
    rst_n = 0;
    idle();
    next_cycle();
    rst_n = 1;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'(i);
    mem[8'h10] = 8'hA5;
    mem[8'h20] = 8'h3C;
    ram_rdata = 8'h00;
    rst_n = 0;
    idle();

    // Reset state
    @(negedge clk);
    chk("rst_cpu_gnt", 32'(cpu_gnt), 32'd0);
    chk("rst_ldr_gnt", 32'(ldr_gnt), 32'd0);
    chk("rst_ram_en", 32'(ram_en), 32'd0);
    chk("rst_ram_we", 32'(ram_we), 32'd0);
    chk("rst_cpu_rvalid", 32'(cpu_rvalid), 32'd0);
    chk("rst_ldr_rvalid", 32'(ldr_rvalid), 32'd0);
    chk("rst_cpu_rdata", 32'(cpu_rdata), 32'd0);
    chk("rst_lock_err", 32'(lock_err), 32'd0);
    next_cycle();
    rst_n = 1;

    // CPU-only read
    next_cycle();
    cpu_req = 1; cpu_addr = 16'h0010;
    @(negedge clk);
    chk("rd_cpu_gnt", 32'(cpu_gnt), 32'd1);
    chk("rd_ram_en", 32'(ram_en), 32'd1);
    chk("rd_ram_we", 32'(ram_we), 32'd0);
    chk("rd_ram_addr", 32'(ram_addr), 32'h10);
    chk("rd_cpu_stall", 32'(cpu_stall), 32'd0);
    next_cycle();
    idle();
    @(negedge clk);
    chk("rd_cpu_rvalid", 32'(cpu_rvalid), 32'd1);
    chk("rd_cpu_rdata", 32'(cpu_rdata), 32'hA5);
    chk("rd_ldr_rvalid", 32'(ldr_rvalid), 32'd0);
    chk("rd_idle_ram_en", 32'(ram_en), 32'd0);

    // Both requesting from reset: CPU, LDR, CPU, LDR
    do_reset();
    for (int i = 0; i < 4; i++) begin
      next_cycle();
      cpu_req = 1; cpu_addr = 16'h0010;
      ldr_req = 1; ldr_addr = 16'h0020;
      @(negedge clk);
      chk($sformatf("rr_cpu_gnt%0d", i), 32'(cpu_gnt), 32'((i % 2) == 0));
      chk($sformatf("rr_ldr_gnt%0d", i), 32'(ldr_gnt), 32'((i % 2) == 1));
      chk($sformatf("rr_stall%0d", i), 32'(cpu_stall), 32'((i % 2) == 1));
      if (i == 1) chk("rr_cpu_rdata", 32'(cpu_rdata), 32'hA5);
      if (i == 2) chk("rr_ldr_rdata", 32'(ldr_rdata), 32'h3C);
      if (i >= 1) chk($sformatf("rr_ldr_rvalid%0d", i), 32'(ldr_rvalid), 32'((i % 2) == 0));
    end

    // Loader lock for 10 cycles with CPU requesting throughout
    do_reset();
    next_cycle();
    idle();
    cpu_req = 1; cpu_we = 1; cpu_addr = 16'h0040; cpu_wdata = 8'h77;
    @(negedge clk);
    chk("lk_pre_cpu_gnt", 32'(cpu_gnt), 32'd1);
    chk("lk_pre_ram_we", 32'(ram_we), 32'd1);
    for (int k = 0; k < 10; k++) begin
      next_cycle();
      cpu_req = 1; cpu_we = 0; cpu_addr = 16'h0010;
      ldr_req = 1; ldr_we = 1; ldr_lock = 1;
      ldr_addr = 16'(16'h0080 + k); ldr_wdata = 8'(8'hC0 + k);
      @(negedge clk);
      chk($sformatf("lk_ldr_gnt%0d", k), 32'(ldr_gnt), 32'd1);
      chk($sformatf("lk_cpu_gnt%0d", k), 32'(cpu_gnt), 32'd0);
      if (k == 3) begin
        chk("lk_ram_addr", 32'(ram_addr), 32'h83);
        chk("lk_ram_wdata", 32'(ram_wdata), 32'hC3);
        chk("lk_stall", 32'(cpu_stall), 32'd1);
      end
    end
    next_cycle();
    ldr_req = 0; ldr_we = 0; ldr_lock = 0;
    @(negedge clk);
    chk("lk_drop_cpu_gnt", 32'(cpu_gnt), 32'd0);
    next_cycle();
    @(negedge clk);
    chk("lk_open_cpu_gnt", 32'(cpu_gnt), 32'd1);
    chk("lk_lock_err", 32'(lock_err), 32'd0);
    chk("lk_mem", 32'(mem[8'h85]), 32'hC5);

    // Forced release on the LOCK_MAX=4 instance
    do_reset();
    next_cycle();
    idle();
    cpu_req = 1; cpu_we = 1; cpu_addr = 16'h0040;
    @(negedge clk);
    chk("fr_pre_cpu_gnt", 32'(cpu_gnt4), 32'd1);
    for (int c = 0; c < 20; c++) begin
      next_cycle();
      cpu_req = 1; cpu_we = 0; cpu_addr = 16'h0010;
      ldr_req = 1; ldr_we = 1; ldr_lock = 1; ldr_addr = 16'h0090;
      @(negedge clk);
      if (c < 4) begin
        chk($sformatf("fr_ldr_gnt%0d", c), 32'(ldr_gnt4), 32'd1);
        chk($sformatf("fr_cpu_gnt%0d", c), 32'(cpu_gnt4), 32'd0);
      end else if (c == 4) begin
        chk("fr_none_ldr", 32'(ldr_gnt4), 32'd0);
        chk("fr_none_cpu", 32'(cpu_gnt4), 32'd0);
        chk("fr_err_before", 32'(lock_err4), 32'd0);
      end else begin
        chk($sformatf("fr_cpu_gnt%0d", c), 32'(cpu_gnt4), 32'(((c - 5) % 2) == 0));
        chk($sformatf("fr_ldr_gnt%0d", c), 32'(ldr_gnt4), 32'(((c - 5) % 2) == 1));
        if (c == 5) chk("fr_lock_err", 32'(lock_err4), 32'd1);
      end
    end
    next_cycle();
    idle();
    @(negedge clk);
    chk("fr_err_sticky", 32'(lock_err4), 32'd1);

    // Reset in the cycle after a granted read
    next_cycle();
    cpu_req = 1; cpu_addr = 16'h0010;
    @(negedge clk);
    chk("mr_cpu_gnt", 32'(cpu_gnt), 32'd1);
    next_cycle();
    idle();
    rst_n = 0;
    @(negedge clk);
    chk("mr_cpu_rvalid", 32'(cpu_rvalid), 32'd0);
    chk("mr_cpu_rdata", 32'(cpu_rdata), 32'd0);
    chk("mr_ram_en", 32'(ram_en), 32'd0);
    chk("mr_lock_err4", 32'(lock_err4), 32'd0);
    next_cycle();
    rst_n = 1;
    cpu_req = 1; cpu_addr = 16'h0010;
    ldr_req = 1; ldr_lock = 1; ldr_addr = 16'h0020;
    @(negedge clk);
    chk("mr_open_cpu_gnt", 32'(cpu_gnt4), 32'd1);
    chk("mr_open_ldr_gnt", 32'(ldr_gnt4), 32'd0);
    next_cycle();
    @(negedge clk);
    chk("mr_open_ldr_next", 32'(ldr_gnt4), 32'd1);
    next_cycle();
    idle();
    @(negedge clk);
    chk("mr_locked_lock_err", 32'(lock_err4), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
